// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads a combinational instruction memory,
// and queues {instr, pc} pairs in a small FIFO presented to decode via valid/ready.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned QDEPTH   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_en,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic [31:0] fetch_count
);

   localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int unsigned CW = $clog2(QDEPTH + 1);

   logic [31:0]   pc;
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;
   logic [31:0]   instr_q [QDEPTH];
   logic [31:0]   pc_q    [QDEPTH];
   logic          pop;
   logic          push;

   assign mem_addr  = pc;
   assign out_valid = (count != '0);
   assign out_instr = instr_q[head];
   assign out_pc    = pc_q[head];

   // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
   assign pop  = out_valid & out_ready;
   assign push = fetch_en & ~redirect_valid & ((count < CW'(QDEPTH)) | pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc          <= RESET_PC;
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         fetch_count <= '0;
         for (int unsigned i = 0; i < QDEPTH; i++) begin
            instr_q[i] <= '0;
            pc_q[i]    <= '0;
         end
      end else if (redirect_valid) begin
         // Redirect discards everything queued; a concurrent pop is implicitly consumed.
         pc    <= {redirect_pc[31:2], 2'b00};
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            instr_q[tail] <= mem_data;
            pc_q[tail]    <= pc;
            tail          <= tail + PW'(1);
            pc            <= pc + 32'd4;
            fetch_count   <= fetch_count + 32'd1;
         end
         if (pop) begin
            head <= head + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule
